matmul_engine: RTL and testbench

Systolic matrix-multiply core fed by the APB register slave. It captures operand matrices A and B and the bias matrix C, then streams skewed rows and columns through a MAX_DIM×MAX_DIM grid of output-stationary MAC cells. It returns the flattened result matrix with per-element overflow flags, and holds `done_o` so the slave can serialize results into the scratchpad.

---
 rtl/matmul_pkg.sv | 23 ++
 rtl/pe_mac.sv | 73 +++++++
 rtl/matmul_engine.sv | 178 +++++++++++++++++
 tb/tb_matmul_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types, defaults and packing helpers for the matmul engine
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int DEF_DW = 8;
    localparam int DEF_BW = 32;

    // Bit offset of element (row, col) in a row-major packed matrix.
    function automatic int row_lsb(int row, int col, int row_w, int el_w);
        return row * row_w + col * el_w;
    endfunction

    function automatic int elem_idx(int i, int j, int dim);
        return i * dim + j;
    endfunction

endpackage

// File: rtl/pe_mac.sv
// rtl/pe_mac.sv - output-stationary MAC cell with registered operand pass-through
module pe_mac
    import matmul_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int BW = DEF_BW
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [BW-1:0] bias_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] a_o,
    output logic [DW-1:0] b_o,
    output logic [BW-1:0] acc_o,
    output logic          of_o
);

    logic [DW-1:0]          a_q, a_d, b_q, b_d;
    logic [BW-1:0]          acc_q, acc_d;
    logic                   of_q, of_d;
    logic signed [2*DW-1:0] prod;
    logic [BW-1:0]          prod_ext, sum;
    logic                   ovf;

    // Overflow: both addends share a sign and the wrapped sum does not.
    always_comb begin
        prod     = (2*DW)'($signed(a_i)) * (2*DW)'($signed(b_i));
        prod_ext = BW'($signed(prod));
        sum      = acc_q + prod_ext;
        ovf      = (acc_q[BW-1] == prod_ext[BW-1]) && (sum[BW-1] != acc_q[BW-1]);
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        of_d  = of_q;
        if (load_i) begin
            a_d   = '0;
            b_d   = '0;
            acc_d = bias_i;
            of_d  = 1'b0;
        end else if (en_i) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = sum;
            of_d  = of_q | ovf;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            of_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            of_q  <= of_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;
    assign of_o  = of_q;

endmodule

// File: rtl/matmul_engine.sv
// rtl/matmul_engine.sv - systolic matrix-multiply core with skewed operand feeds
module matmul_engine
    import matmul_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int BW           = DEF_BW,
    parameter int MAX_DIM      = BW / DW,
    parameter int Elements_Num = MAX_DIM * MAX_DIM
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       start_i,
    input  logic [1:0]                 n_dim_i,
    input  logic [1:0]                 k_dim_i,
    input  logic [1:0]                 m_dim_i,
    input  logic [BW*MAX_DIM-1:0]      operand_a_i,
    input  logic [BW*MAX_DIM-1:0]      operand_b_i,
    input  logic [BW*Elements_Num-1:0] operand_c_i,
    output logic [BW*Elements_Num-1:0] result_o,
    output logic [Elements_Num-1:0]    of_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int RunMax = MAX_DIM + 2 * (MAX_DIM - 1);
    localparam int CntW   = $clog2(RunMax + 1);
    localparam int IdxW   = $clog2(MAX_DIM);

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [BW*MAX_DIM-1:0]   a_mat_q, a_mat_d, b_mat_q, b_mat_d;
    logic [1:0]              n_q, n_d, k_q, k_d, m_q, m_d;
    logic                    load_en, run_en;
    logic [CntW-1:0]         run_last_t;
    logic                    in_k;
    logic [DW-1:0]           a_raw [MAX_DIM];
    logic [DW-1:0]           b_raw [MAX_DIM];
    logic [DW-1:0]           a_link [MAX_DIM][MAX_DIM+1];
    logic [DW-1:0]           b_link [MAX_DIM+1][MAX_DIM];

    assign run_last_t = CntW'(k_q) + CntW'(2 * (MAX_DIM - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_RUN;
            ST_RUN:  if (cnt_q == run_last_t) state_d = ST_DONE;
            ST_DONE: if (!start_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_en = (state_q == ST_LOAD);
        run_en  = (state_q == ST_RUN);
        busy_o  = (state_q != ST_IDLE);
        done_o  = (state_q == ST_DONE);
    end

    always_comb begin
        a_mat_d = a_mat_q;
        b_mat_d = b_mat_q;
        n_d     = n_q;
        k_d     = k_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        if (load_en) begin
            a_mat_d = operand_a_i;
            b_mat_d = operand_b_i;
            n_d     = n_dim_i;
            k_d     = k_dim_i;
            m_d     = m_dim_i;
            cnt_d   = '0;
        end else if (run_en) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            a_mat_q <= '0;
            b_mat_q <= '0;
            n_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            a_mat_q <= a_mat_d;
            b_mat_q <= b_mat_d;
            n_q     <= n_d;
            k_q     <= k_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    // Unskewed streams: step t carries A(i,t) / B(t,j); the delay lines add the skew.
    assign in_k = (cnt_q <= CntW'(k_q));

    always_comb begin
        for (int i = 0; i < MAX_DIM; i++) begin
            a_raw[i] = '0;
            b_raw[i] = '0;
            if (in_k && i <= int'(n_q))
                a_raw[i] = a_mat_q[row_lsb(i, int'(cnt_q[IdxW-1:0]), BW, DW) +: DW];
            if (in_k && i <= int'(m_q))
                b_raw[i] = b_mat_q[row_lsb(int'(cnt_q[IdxW-1:0]), i, BW, DW) +: DW];
        end
    end

    for (genvar i = 0; i < MAX_DIM; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_link[0][0] = a_raw[0];
            assign b_link[0][0] = b_raw[0];
        end else begin : g_delay
            logic [DW*i-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;

            always_comb begin
                a_sr_d = a_sr_q;
                b_sr_d = b_sr_q;
                if (load_en) begin
                    a_sr_d = '0;
                    b_sr_d = '0;
                end else if (run_en) begin
                    a_sr_d = (DW*i)'({a_sr_q, a_raw[i]});
                    b_sr_d = (DW*i)'({b_sr_q, b_raw[i]});
                end
            end

            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    a_sr_q <= '0;
                    b_sr_q <= '0;
                end else begin
                    a_sr_q <= a_sr_d;
                    b_sr_q <= b_sr_d;
                end
            end

            assign a_link[i][0] = a_sr_q[DW*i-1 -: DW];
            assign b_link[0][i] = b_sr_q[DW*i-1 -: DW];
        end
    end

    // Out-of-range cells start from zero so they read back as 0 with no overflow.
    for (genvar i = 0; i < MAX_DIM; i++) begin : g_grid_row
        for (genvar j = 0; j < MAX_DIM; j++) begin : g_grid_col
            logic [BW-1:0] bias;

            assign bias = (i <= int'(n_dim_i) && j <= int'(m_dim_i))
                        ? operand_c_i[BW*elem_idx(i, j, MAX_DIM) +: BW] : '0;

            pe_mac #(
                .DW (DW),
                .BW (BW)
            ) u_pe (
                .clk_i    (clk_i),
                .reset_ni (reset_ni),
                .load_i   (load_en),
                .en_i     (run_en),
                .bias_i   (bias),
                .a_i      (a_link[i][j]),
                .b_i      (b_link[i][j]),
                .a_o      (a_link[i][j+1]),
                .b_o      (b_link[i+1][j]),
                .acc_o    (result_o[BW*elem_idx(i, j, MAX_DIM) +: BW]),
                .of_o     (of_o[elem_idx(i, j, MAX_DIM)])
            );
        end
    end

endmodule

// File: tb/tb_matmul_engine.sv
// tb/tb_matmul_engine.sv - randomized self-checking bench for matmul_engine
module tb_matmul_engine;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic         start_i;
    logic [1:0]   n_dim_i, k_dim_i, m_dim_i;
    logic [127:0] operand_a_i, operand_b_i;
    logic [511:0] operand_c_i;
    logic [511:0] result_o;
    logic [15:0]  of_o;
    logic         busy_o, done_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [7:0] am [4][4];
    logic signed [7:0] bm [4][4];
    logic [31:0]       cm [4][4];
    int                n, k, m;
    logic [511:0]      exp_res;
    logic [15:0]       exp_of;

    always #5 clk_i = ~clk_i;

    matmul_engine dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .start_i     (start_i),
        .n_dim_i     (n_dim_i),
        .k_dim_i     (k_dim_i),
        .m_dim_i     (m_dim_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .operand_c_i (operand_c_i),
        .result_o    (result_o),
        .of_o        (of_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic pack_inputs();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                operand_a_i[32*r + 8*c +: 8]    = am[r][c];
                operand_b_i[32*r + 8*c +: 8]    = bm[r][c];
                operand_c_i[32*(4*r + c) +: 32] = cm[r][c];
            end
        n_dim_i = 2'(n);
        k_dim_i = 2'(k);
        m_dim_i = 2'(m);
    endtask

    // Reference: C + sum over kk of A*B in 32-bit wrapping arithmetic, sticky signed overflow.
    task automatic compute_model();
        int acc, p, s;
        bit of;
        exp_res = '0;
        exp_of  = '0;
        for (int i = 0; i <= n; i++)
            for (int j = 0; j <= m; j++) begin
                acc = int'(cm[i][j]);
                of  = 1'b0;
                for (int kk = 0; kk <= k; kk++) begin
                    p = int'(am[i][kk]) * int'(bm[kk][j]);
                    s = acc + p;
                    if (((acc < 0) == (p < 0)) && ((s < 0) != (acc < 0))) of = 1'b1;
                    acc = s;
                end
                exp_res[32*(4*i + j) +: 32] = acc;
                exp_of[4*i + j]             = of;
            end
    endtask

    task automatic randomize_mats();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                am[r][c] = 8'($urandom);
                bm[r][c] = 8'($urandom);
                cm[r][c] = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 200)) - 32'd100;
            end
        n = $urandom_range(0, 3);
        k = $urandom_range(0, 3);
        m = $urandom_range(0, 3);
    endtask

    // Start an operation and wait for done; lat is the cycle number (LOAD = 1) or -1 on timeout.
    task automatic do_op(input bit drop, output int lat, output bit busy_seen);
        int cyc;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        cyc       = 1;
        busy_seen = busy_o;
        @(posedge clk_i); #1;
        cyc = 2;
        operand_a_i = {$urandom, $urandom, $urandom, $urandom};
        operand_b_i = {$urandom, $urandom, $urandom, $urandom};
        for (int e = 0; e < 16; e++) operand_c_i[32*e +: 32] = $urandom;
        n_dim_i = 2'($urandom);
        k_dim_i = 2'($urandom);
        m_dim_i = 2'($urandom);
        if (drop) start_i = 1'b0;
        while (!done_o && cyc < 60) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        lat = done_o ? cyc : -1;
    endtask

    task automatic end_op();
        start_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        start_i  = 1'b0;
        n_dim_i = '0; k_dim_i = '0; m_dim_i = '0;
        operand_a_i = '0; operand_b_i = '0; operand_c_i = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_ni = 1'b1;
        @(posedge clk_i); #1;
        n_checks++;
        if (result_o !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result_o); end
        n_checks++;
        if (of_o !== '0) begin n_fail++; $display("FAIL reset_of: got %h expected 0", of_o); end
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy %b done %b expected 0 0", busy_o, done_o);
        end
    endtask

    task automatic check_op(input string name, input int lat, input int exp_lat);
        n_checks++;
        if (lat !== exp_lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
        n_checks++;
        if (result_o !== exp_res) begin n_fail++; $display("FAIL %s_result: got %h expected %h", name, result_o, exp_res); end
        n_checks++;
        if (of_o !== exp_of) begin n_fail++; $display("FAIL %s_of: got %h expected %h", name, of_o, exp_of); end
    endtask

    task automatic test_identity();
        int lat; bit bs;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                am[r][c] = (r == c) ? 8'sd1 : 8'sd0;
                bm[r][c] = 8'(4*r + c + 1);
                cm[r][c] = '0;
            end
        n = 3; k = 3; m = 3;
        pack_inputs();
        compute_model();
        do_op(1'b0, lat, bs);
        check_op("identity", lat, 12);
        n_checks++;
        if (result_o[32*5 +: 32] !== 32'd6) begin n_fail++; $display("FAIL identity_elem11: got %0d expected 6", result_o[32*5 +: 32]); end
        end_op();
    endtask

    task automatic test_overflow();
        int lat; bit bs;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                am[r][c] = 8'h80;
                bm[r][c] = 8'h80;
                cm[r][c] = '0;
            end
        cm[0][0] = 32'h7FFF_FFFF;
        n = 3; k = 3; m = 3;
        pack_inputs();
        compute_model();
        do_op(1'b0, lat, bs);
        check_op("overflow", lat, 12);
        n_checks++;
        if (result_o[31:0] !== 32'h8000_FFFF || of_o[0] !== 1'b1 || result_o[63:32] !== 32'h0001_0000) begin
            n_fail++; $display("FAIL overflow_elems: got %h of0 %b elem1 %h expected 8000ffff 1 00010000",
                               result_o[31:0], of_o[0], result_o[63:32]);
        end
        end_op();
    endtask

    task automatic test_small_dims();
        int lat; bit bs;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                am[r][c] = 8'sd2;
                bm[r][c] = 8'sd2;
                cm[r][c] = 32'd5;
            end
        n = 1; k = 2; m = 1;
        pack_inputs();
        compute_model();
        do_op(1'b0, lat, bs);
        check_op("small_dims", lat, 11);
        n_checks++;
        if (result_o[32*4 +: 32] !== 32'd17 || result_o[32*2 +: 32] !== 32'd0) begin
            n_fail++; $display("FAIL small_dims_elems: got %0d %0d expected 17 0", result_o[32*4 +: 32], result_o[32*2 +: 32]);
        end
        end_op();
    endtask

    task automatic test_negative();
        int lat; bit bs;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                am[r][c] = -8'sd1;
                bm[r][c] = -8'sd1;
                cm[r][c] = -32'sd20;
            end
        n = 3; k = 3; m = 3;
        pack_inputs();
        compute_model();
        do_op(1'b0, lat, bs);
        check_op("negative", lat, 12);
        n_checks++;
        if (result_o[32*15 +: 32] !== 32'hFFFF_FFF0) begin
            n_fail++; $display("FAIL negative_elem15: got %h expected fffffff0", result_o[32*15 +: 32]);
        end
        end_op();
    endtask

    task automatic test_random();
        int lat; bit bs;
        for (int it = 0; it < 10; it++) begin
            randomize_mats();
            pack_inputs();
            compute_model();
            do_op(it[0], lat, bs);
            n_checks++;
            if (bs !== 1'b1) begin n_fail++; $display("FAIL random_busy_rise: got %b expected 1", bs); end
            check_op("random", lat, 2 + (k + 1) + 6);
            end_op();
            n_checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL random_fall: done %b busy %b expected 0 0", done_o, busy_o);
            end
        end
    endtask

    task automatic test_hold_start();
        int lat; bit bs;
        logic [511:0] held;
        randomize_mats();
        pack_inputs();
        compute_model();
        do_op(1'b0, lat, bs);
        check_op("hold", lat, 2 + (k + 1) + 6);
        held = result_o;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i); #1;
            n_checks++;
            if (done_o !== 1'b1 || result_o !== held) begin
                n_fail++; $display("FAIL hold_cycle%0d: done %b result %h expected 1 %h", c, done_o, result_o, held);
            end
        end
        end_op();
        n_checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: done %b busy %b expected 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_async_reset();
        int lat; bit bs;
        randomize_mats();
        k = 3;
        pack_inputs();
        compute_model();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        repeat (4) @(posedge clk_i);
        #3 reset_ni = 1'b0;
        #1;
        n_checks++;
        if (result_o !== '0 || of_o !== '0) begin
            n_fail++; $display("FAIL async_reset_data: result %h of %h expected 0 0", result_o, of_o);
        end
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_flags: busy %b done %b expected 0 0", busy_o, done_o);
        end
        #1 reset_ni = 1'b1;
        pack_inputs();
        do_op(1'b0, lat, bs);
        n_checks++;
        if (bs !== 1'b1) begin n_fail++; $display("FAIL async_restart_busy: got %b expected 1", bs); end
        check_op("async_restart", lat, 12);
        end_op();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_overflow();
        test_small_dims();
        test_negative();
        test_random();
        test_hold_start();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
